// File: rtl/data_mem_responder.sv
// Memory-side responder: four byte-lane RAM banks with a word fetch port and a misaligned-capable
// byte data port, plus an MMIO window holding a console TX FIFO, a cycle counter and a halt flag.
module data_mem_responder #(
   parameter int          DEPTH_WORDS   = 4096,
   parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000,
   parameter int          TX_FIFO_DEPTH = 8,
   parameter string       INIT_FILE     = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic [29:0] i_fetch_addr,
   output logic [31:0] o_fetch_data,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_rvalid,
   output logic [31:0] o_rdata,
   output logic        o_bus_error,
   output logic        o_tx_valid,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_ready,
   output logic        o_halt
);
   localparam int          RW        = $clog2(DEPTH_WORDS);
   localparam int          PW        = $clog2(TX_FIFO_DEPTH);
   localparam int          CW        = PW + 1;
   localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);
   localparam logic [32:0] MMIO_LO   = {1'b0, MMIO_BASE};
   localparam logic [32:0] MMIO_HI   = {1'b0, MMIO_BASE} + 33'd16;

   typedef enum logic [1:0] {
      REG_TX    = 2'd0,
      REG_CYCLE = 2'd1,
      REG_HALT  = 2'd2,
      REG_RSVD  = 2'd3
   } mmio_reg_e;

   // ---------------- access decode ----------------
   logic [1:0]  a_lo;
   logic [2:0]  n_bytes;
   logic [32:0] last_byte;
   logic        in_mmio, in_ram, fault;
   logic        acc, ram_acc, mmio_acc;
   mmio_reg_e   mmio_sel;

   assign a_lo      = i_addr[1:0];
   assign n_bytes   = 3'd1 << i_size;
   assign last_byte = {1'b0, i_addr} + {30'd0, n_bytes} - 33'd1;
   assign in_mmio   = ({1'b0, i_addr} >= MMIO_LO) && ({1'b0, i_addr} < MMIO_HI);
   assign in_ram    = last_byte < RAM_BYTES;
   assign mmio_sel  = mmio_reg_e'(i_addr[3:2]);
   // Any faulting condition aborts the whole access, so partial lane writes never happen.
   assign fault     = (i_size == 2'd3) ||
                      (in_mmio ? (i_size != 2'd2 || a_lo != 2'd0) : !in_ram);
   assign acc       = clk_en && i_req && !fault;
   assign ram_acc   = acc && !in_mmio;
   assign mmio_acc  = acc && in_mmio;

   // ---------------- byte-lane banks ----------------
   logic [RW-1:0]       word_row, fetch_row;
   logic [3:0][RW-1:0]  lane_row;
   logic [3:0][1:0]     lane_off;
   logic [3:0]          lane_act;
   logic [3:0][7:0]     lane_rd;
   logic [3:0][7:0]     fetch_rd;
   logic                unused_fetch_hi;

   assign word_row        = i_addr[RW+1:2];
   assign fetch_row       = i_fetch_addr[RW-1:0];
   assign unused_fetch_hi = ^i_fetch_addr[29:RW];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];

      assign lane_off[k] = 2'(k) - a_lo;
      assign lane_act[k] = {1'b0, lane_off[k]} < n_bytes;
      // Lanes below the start lane hold the bytes that spill into the next word.
      assign lane_row[k] = word_row + RW'(2'(k) < a_lo);
      assign lane_rd[k]  = ram[lane_row[k]];
      assign fetch_rd[k] = ram[fetch_row];

      // NOTE: RAM contents are intentionally left out of reset; only control state is cleared.
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (ram_acc && i_we && lane_act[k]) ram[lane_row[k]] <= i_wdata[8*lane_off[k] +: 8];
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem [TX_FIFO_DEPTH];
   logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [CW-1:0] tx_count;
   logic          tx_full, tx_empty, tx_ovf;
   logic          tx_push_req, tx_push, tx_pop, tx_status_rd;
   logic [CW+5:0] tx_status;

   assign tx_full      = tx_count == CW'(TX_FIFO_DEPTH);
   assign tx_empty     = tx_count == '0;
   assign tx_pop       = o_tx_valid && i_tx_ready;
   assign tx_push_req  = mmio_acc && i_we && mmio_sel == REG_TX;
   assign tx_push      = tx_push_req && (!tx_full || tx_pop);
   assign tx_status_rd = mmio_acc && !i_we && mmio_sel == REG_TX;
   assign tx_status    = {tx_count, 3'b000, tx_ovf, tx_empty, tx_full};
   assign o_tx_valid   = !tx_empty;
   assign o_tx_data    = tx_mem[tx_rd_ptr];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= i_wdata[7:0];
   end

   // The drain side runs on every clk; the push side is already qualified by clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_count  <= '0;
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_ovf    <= 1'b0;
      end else begin
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
         if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
         else if (tx_status_rd)       tx_ovf <= 1'b0;
      end
   end

   // ---------------- cycle counter and halt ----------------
   logic [31:0] cycle_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         o_halt    <= 1'b0;
      end else if (clk_en) begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (mmio_acc && i_we && mmio_sel == REG_HALT) o_halt <= 1'b1;
      end
   end

   // ---------------- read data ----------------
   logic [31:0] ram_rdata, mmio_rdata;

   always_comb begin
      // NOTE: defaults are assigned first so no path through this block infers a latch.
      ram_rdata = '0;
      for (int j = 0; j < 4; j++) begin
         if (3'(j) < n_bytes) ram_rdata[8*j +: 8] = lane_rd[a_lo + 2'(j)];
      end
   end

   always_comb begin
      mmio_rdata = '0;
      case (mmio_sel)
         REG_TX:    mmio_rdata = 32'(tx_status);
         REG_CYCLE: mmio_rdata = cycle_cnt;
         REG_HALT:  mmio_rdata = {31'd0, o_halt};
         REG_RSVD:  mmio_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_fetch_data <= '0;
         o_rvalid     <= 1'b0;
         o_rdata      <= '0;
         o_bus_error  <= 1'b0;
      end else if (clk_en) begin
         o_fetch_data <= fetch_rd;
         o_rvalid     <= i_req && !i_we;
         o_bus_error  <= i_req && fault;
         if (i_req && !i_we) o_rdata <= fault ? '0 : (in_mmio ? mmio_rdata : ram_rdata);
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM banking, faults, TX FIFO, halt and cycle counter.
module tb_data_mem_responder;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] MB    = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst, clk_en;
   logic [29:0] i_fetch_addr;
   logic [31:0] o_fetch_data;
   logic        i_req, i_we;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_wdata;
   logic        o_rvalid;
   logic [31:0] o_rdata;
   logic        o_bus_error, o_tx_valid;
   logic [7:0]  o_tx_data;
   logic        i_tx_ready, o_halt;
   logic [31:0] cyc1;

   int n_checks = 0;
   int n_fail   = 0;

   data_mem_responder #(
      .DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .TX_FIFO_DEPTH(8), .INIT_FILE("")
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .i_fetch_addr(i_fetch_addr), .o_fetch_data(o_fetch_data),
      .i_req(i_req), .i_we(i_we), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_bus_error(o_bus_error),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .o_halt(o_halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
      i_req = 1'b1; i_we = we; i_size = size; i_addr = addr; i_wdata = wdata;
      tick();
      i_req = 1'b0; i_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clk_en = 1'b1; i_req = 1'b0; i_we = 1'b0; i_size = 2'd0;
      i_addr = '0; i_wdata = '0; i_fetch_addr = '0; i_tx_ready = 1'b0;
      tick(); tick();
      check("rst_fetch",    o_fetch_data,       32'h0);
      check("rst_rvalid",   32'(o_rvalid),      32'h0);
      check("rst_rdata",    o_rdata,            32'h0);
      check("rst_buserr",   32'(o_bus_error),   32'h0);
      check("rst_halt",     32'(o_halt),        32'h0);
      check("rst_txvalid",  32'(o_tx_valid),    32'h0);
      rst = 1'b0;

      // Aligned word, byte and half accesses
      access(1'b1, 2'd2, 32'h100, 32'h11223344);
      check("sw_no_rvalid", 32'(o_rvalid), 32'h0);
      access(1'b0, 2'd2, 32'h100, 32'h0);
      check("lw_rvalid", 32'(o_rvalid), 32'h1);
      check("lw_100",    o_rdata,       32'h11223344);
      access(1'b0, 2'd0, 32'h103, 32'h0);
      check("lb_103",    o_rdata,       32'h11);
      access(1'b0, 2'd1, 32'h101, 32'h0);
      check("lh_101",    o_rdata,       32'h2233);
      tick();
      check("rvalid_drop", 32'(o_rvalid), 32'h0);

      // Word-crossing store and load
      access(1'b1, 2'd2, 32'h1FC, 32'h01020304);
      access(1'b1, 2'd2, 32'h200, 32'h05060708);
      access(1'b1, 2'd2, 32'h1FE, 32'hAABBCCDD);
      access(1'b0, 2'd2, 32'h1FE, 32'h0);
      check("lw_cross",        o_rdata,          32'hAABBCCDD);
      check("lw_cross_noerr",  32'(o_bus_error), 32'h0);
      access(1'b0, 2'd2, 32'h1FC, 32'h0);
      check("lw_1fc",          o_rdata,          32'hCCDD0304);
      access(1'b0, 2'd2, 32'h200, 32'h0);
      check("lw_200",          o_rdata,          32'h0506AABB);
      i_fetch_addr = 30'h7F;
      tick();
      check("fetch_1fc",       o_fetch_data,     32'hCCDD0304);

      // Top-of-RAM boundary and other faults
      access(1'b1, 2'd2, 32'h3FFC, 32'hCAFEF00D);
      access(1'b0, 2'd1, 32'h3FFF, 32'h0);
      check("lh_oob_err",    32'(o_bus_error), 32'h1);
      check("lh_oob_rvalid", 32'(o_rvalid),    32'h1);
      check("lh_oob_rdata",  o_rdata,          32'h0);
      tick();
      check("err_pulse_end", 32'(o_bus_error), 32'h0);
      access(1'b1, 2'd2, 32'h3FFF, 32'h12345678);
      check("sw_oob_err",    32'(o_bus_error), 32'h1);
      access(1'b0, 2'd2, 32'h3FFC, 32'h0);
      check("top_intact",    o_rdata,          32'hCAFEF00D);
      access(1'b0, 2'd0, 32'h3FFF, 32'h0);
      check("lb_last_byte",  o_rdata,          32'hCA);
      check("lb_last_noerr", 32'(o_bus_error), 32'h0);
      access(1'b1, 2'd3, 32'h100, 32'h0);
      check("size3_err",     32'(o_bus_error), 32'h1);
      access(1'b0, 2'd1, MB, 32'h0);
      check("mmio_half_err", 32'(o_bus_error), 32'h1);
      access(1'b1, 2'd2, MB + 32'd1, 32'h55);
      check("mmio_misal_err", 32'(o_bus_error), 32'h1);
      access(1'b0, 2'd2, 32'h100, 32'h0);
      check("size3_nowrite", o_rdata,          32'h11223344);

      // Read-before-write between store and fetch of the same word
      access(1'b1, 2'd2, 32'h40, 32'h0BADF00D);
      i_fetch_addr = 30'h10;
      access(1'b1, 2'd2, 32'h40, 32'h600DCAFE);
      check("fetch_rbw",  o_fetch_data, 32'h0BADF00D);
      access(1'b0, 2'd2, 32'h40, 32'h0);
      check("load_new",   o_rdata,      32'h600DCAFE);
      check("fetch_new",  o_fetch_data, 32'h600DCAFE);

      // TX FIFO overflow and in-order drain (drain runs with clk_en low)
      check("tx_empty", 32'(o_tx_valid), 32'h0);
      for (int i = 0; i < 9; i++) begin
         access(1'b1, 2'd2, MB, 32'hA0 + 32'(i));
         if (i == 0) check("tx_valid_after_push", 32'(o_tx_valid), 32'h1);
      end
      access(1'b0, 2'd2, MB, 32'h0);
      check("tx_status_ovf",  o_rdata, 32'h205);
      access(1'b0, 2'd2, MB, 32'h0);
      check("tx_status_clr",  o_rdata, 32'h201);
      clk_en = 1'b0; i_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_drain_valid", 32'(o_tx_valid), 32'h1);
         check("tx_drain_data",  32'(o_tx_data),  32'hA0 + 32'(i));
         tick();
      end
      check("tx_drained", 32'(o_tx_valid), 32'h0);
      i_tx_ready = 1'b0; clk_en = 1'b1;
      access(1'b0, 2'd2, MB, 32'h0);
      check("tx_status_empty", o_rdata, 32'h002);

      // Push and pop together while full
      for (int i = 0; i < 8; i++) access(1'b1, 2'd2, MB, 32'hB0 + 32'(i));
      i_tx_ready = 1'b1;
      access(1'b1, 2'd2, MB, 32'hB8);
      i_tx_ready = 1'b0;
      access(1'b0, 2'd2, MB, 32'h0);
      check("tx_full_pushpop", o_rdata, 32'h201);
      i_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_pp_data", 32'(o_tx_data), 32'hB1 + 32'(i));
         tick();
      end
      i_tx_ready = 1'b0;
      check("tx_pp_drained", 32'(o_tx_valid), 32'h0);

      // Halt, reserved register, clk_en freeze
      access(1'b1, 2'd2, MB + 32'h8, 32'h0);
      check("halt_set", 32'(o_halt), 32'h1);
      tick(); tick();
      check("halt_sticky", 32'(o_halt), 32'h1);
      access(1'b0, 2'd2, MB + 32'h8, 32'h0);
      check("halt_read", o_rdata, 32'h1);
      access(1'b0, 2'd2, MB + 32'hC, 32'h0);
      check("rsvd_read", o_rdata, 32'h0);
      clk_en = 1'b0;
      access(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
      clk_en = 1'b1;
      access(1'b0, 2'd2, 32'h100, 32'h0);
      check("clken_nowrite", o_rdata, 32'h11223344);

      // Reset in the middle of a load with a byte queued
      access(1'b1, 2'd2, MB, 32'h77);
      check("tx_queued", 32'(o_tx_valid), 32'h1);
      rst = 1'b1; i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_addr = 32'h100;
      tick();
      i_req = 1'b0; rst = 1'b0;
      check("rst_load_dropped", 32'(o_rvalid),   32'h0);
      check("rst_halt_clr",     32'(o_halt),     32'h0);
      check("rst_tx_lost",      32'(o_tx_valid), 32'h0);

      // Cycle counter
      repeat (10) tick();
      access(1'b0, 2'd2, MB + 32'h4, 32'h0);
      cyc1 = o_rdata;
      check("cycle_after_10", 32'(cyc1 inside {[32'd9:32'd11]}), 32'h1);
      clk_en = 1'b0;
      repeat (5) tick();
      clk_en = 1'b1;
      access(1'b0, 2'd2, MB + 32'h4, 32'h0);
      check("cycle_frozen", o_rdata - cyc1, 32'h1);
      access(1'b0, 2'd2, MB, 32'h0);
      check("tx_status_post_rst", o_rdata, 32'h002);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
